// File: rtl/bus_arb_rr.sv
// Round-robin RAM port arbiter: CPU owns the port by default, DMA channels
// win bounded bursts in rotation, and every burst is followed by a CPU window.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cpu_*                CPU address/data/strobes, cpu_arbitrate, cpu_ack
//   dma_req/ack          per-channel request, one-hot grant
//   dma_addr/data/rd/wr  packed per-channel DMA bus
//   ram_*                muxed RAM port
//   owner, burst_cnt     granted channel (0 when CPU), beats used in burst
module bus_arb_rr #(
  parameter int NCHAN      = 4,
  parameter int BURST      = 4,
  parameter int CPU_GAP    = 1,
  parameter int ADDR_W     = 22,
  parameter int DMA_ADDR_W = 18,
  parameter int DATA_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_data,
  input  logic                         cpu_rd,
  input  logic                         cpu_wr,
  input  logic                         cpu_byte_op,
  input  logic                         cpu_arbitrate,
  output logic                         cpu_ack,
  input  logic [NCHAN-1:0]             dma_req,
  output logic [NCHAN-1:0]             dma_ack,
  input  logic [NCHAN*DMA_ADDR_W-1:0]  dma_addr,
  input  logic [NCHAN*DATA_W-1:0]      dma_data,
  input  logic [NCHAN-1:0]             dma_rd,
  input  logic [NCHAN-1:0]             dma_wr,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [DATA_W-1:0]            ram_data_out,
  output logic                         ram_rd,
  output logic                         ram_wr,
  output logic                         ram_byte_op,
  output logic [2:0]                   owner,
  output logic [3:0]                   burst_cnt
);

  localparam int IW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam logic [3:0] LAST_BEAT = 4'(BURST - 1);
  // The CPU cycle in which the next grant is decided counts toward
  // the window, so GAP itself only needs CPU_GAP-1 cycles.
  localparam logic [3:0] GAP_LOAD = 4'((CPU_GAP > 1) ? CPU_GAP - 2 : 0);
  localparam logic [IW-1:0] LAST_RST = IW'(NCHAN - 1);

  typedef enum logic [1:0] {
    S_CPU = 2'd0,
    S_DMA = 2'd1,
    S_GAP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] own_q, own_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] win;
  logic          win_vld;
  logic [IW:0]   scan;
  logic [3:0]    beat_q, beat_d;
  logic [3:0]    gap_q, gap_d;

  logic [DMA_ADDR_W-1:0] ch_addr [NCHAN];
  logic [DATA_W-1:0]     ch_data [NCHAN];

  for (genvar i = 0; i < NCHAN; i++) begin : g_unpack
    assign ch_addr[i] = dma_addr[i*DMA_ADDR_W +: DMA_ADDR_W];
    assign ch_data[i] = dma_data[i*DATA_W +: DATA_W];
  end

  // Scan last+1, last+2, ... wrapping; first requester wins.
  always_comb begin
    win     = last_q;
    win_vld = 1'b0;
    scan    = '0;
    for (int k = 1; k <= NCHAN; k++) begin
      scan = {1'b0, last_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NCHAN))
        scan = scan - (IW+1)'(NCHAN);
      if (!win_vld && dma_req[scan[IW-1:0]]) begin
        win_vld = 1'b1;
        win     = scan[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CPU;
      own_q   <= '0;
      last_q  <= LAST_RST;
      beat_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    unique case (state_q)
      S_CPU: begin
        if (cpu_arbitrate && win_vld) begin
          state_d = S_DMA;
          own_d   = win;
          beat_d  = '0;
        end
      end
      S_DMA: begin
        if (!dma_req[own_q] || beat_q == LAST_BEAT) begin
          last_d = own_q;
          beat_d = '0;
          if (CPU_GAP > 1) begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end else begin
            state_d = S_CPU;
          end
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0)
          state_d = S_CPU;
        else
          gap_d = gap_q - 4'd1;
      end
      default: state_d = S_CPU;
    endcase
  end

  // CPU inputs pass straight through unless a channel holds the grant.
  always_comb begin
    cpu_ack      = 1'b1;
    dma_ack      = '0;
    owner        = 3'd0;
    ram_addr     = cpu_addr;
    ram_data_out = cpu_data;
    ram_rd       = cpu_rd;
    ram_wr       = cpu_wr;
    ram_byte_op  = cpu_byte_op;
    if (state_q == S_DMA) begin
      cpu_ack        = 1'b0;
      dma_ack[own_q] = 1'b1;
      owner          = 3'(own_q);
      ram_addr       = ADDR_W'(ch_addr[own_q]);
      ram_data_out   = ch_data[own_q];
      ram_rd         = dma_rd[own_q];
      ram_wr         = dma_wr[own_q];
      ram_byte_op    = 1'b0;
    end
  end

  assign burst_cnt = beat_q;

endmodule

// File: tb/tb_bus_arb_rr.sv
// Self-checking bench for bus_arb_rr: vector table, directed corner
// sequences, and randomized traffic against a behavioural model.
module tb_bus_arb_rr;

  localparam int NCHAN      = 4;
  localparam int BURST      = 4;
  localparam int CPU_GAP    = 1;
  localparam int ADDR_W     = 22;
  localparam int DMA_ADDR_W = 18;
  localparam int DATA_W     = 16;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [ADDR_W-1:0]           cpu_addr;
  logic [DATA_W-1:0]           cpu_data;
  logic                        cpu_rd, cpu_wr, cpu_byte_op;
  logic                        cpu_arbitrate;
  logic                        cpu_ack;
  logic [NCHAN-1:0]            dma_req;
  logic [NCHAN-1:0]            dma_ack;
  logic [NCHAN*DMA_ADDR_W-1:0] dma_addr;
  logic [NCHAN*DATA_W-1:0]     dma_data;
  logic [NCHAN-1:0]            dma_rd, dma_wr;
  logic [ADDR_W-1:0]           ram_addr;
  logic [DATA_W-1:0]           ram_data_out;
  logic                        ram_rd, ram_wr, ram_byte_op;
  logic [2:0]                  owner;
  logic [3:0]                  burst_cnt;

  bus_arb_rr #(
    .NCHAN(NCHAN), .BURST(BURST), .CPU_GAP(CPU_GAP),
    .ADDR_W(ADDR_W), .DMA_ADDR_W(DMA_ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byte_op(cpu_byte_op),
    .cpu_arbitrate(cpu_arbitrate), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_ack(dma_ack),
    .dma_addr(dma_addr), .dma_data(dma_data),
    .dma_rd(dma_rd), .dma_wr(dma_wr),
    .ram_addr(ram_addr), .ram_data_out(ram_data_out),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_byte_op(ram_byte_op),
    .owner(owner), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: is a burst running, who owns it, how many beats are used,
  // who won last, and how many more CPU cycles must pass before a grant.
  bit m_dma;
  int m_owner, m_used, m_last, m_hold;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [DMA_ADDR_W-1:0] ch_addr(input int c);
    return dma_addr[c*DMA_ADDR_W +: DMA_ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] ch_data(input int c);
    return dma_data[c*DATA_W +: DATA_W];
  endfunction

  function automatic bit bit_of(input logic [NCHAN-1:0] v, input int c);
    return ((v >> c) & 1) != 0;
  endfunction

  task automatic model_check();
    logic [NCHAN-1:0] e_ack;
    e_ack = '0;
    if (m_dma) e_ack = NCHAN'(1) << m_owner;
    chk("cpu_ack", 32'(cpu_ack), 32'(!m_dma));
    chk("dma_ack", 32'(dma_ack), 32'(e_ack));
    chk("owner", 32'(owner), m_dma ? 32'(m_owner) : 32'd0);
    chk("burst_cnt", 32'(burst_cnt), m_dma ? 32'(m_used) : 32'd0);
    if (m_dma) begin
      chk("ram_addr", 32'(ram_addr), 32'(ch_addr(m_owner)));
      chk("ram_data", 32'(ram_data_out), 32'(ch_data(m_owner)));
      chk("ram_rd", 32'(ram_rd), 32'(bit_of(dma_rd, m_owner)));
      chk("ram_wr", 32'(ram_wr), 32'(bit_of(dma_wr, m_owner)));
      chk("ram_byte_op", 32'(ram_byte_op), 32'd0);
    end else begin
      chk("ram_addr", 32'(ram_addr), 32'(cpu_addr));
      chk("ram_data", 32'(ram_data_out), 32'(cpu_data));
      chk("ram_rd", 32'(ram_rd), 32'(cpu_rd));
      chk("ram_wr", 32'(ram_wr), 32'(cpu_wr));
      chk("ram_byte_op", 32'(ram_byte_op), 32'(cpu_byte_op));
    end
  endtask

  // Apply the rules for the upcoming clock edge.
  task automatic model_step();
    bit found;
    int c;
    if (reset) begin
      m_dma = 0; m_owner = 0; m_used = 0;
      m_last = NCHAN - 1; m_hold = 0;
      return;
    end
    if (m_dma) begin
      m_used++;
      if (!bit_of(dma_req, m_owner) || m_used == BURST) begin
        m_dma  = 0;
        m_last = m_owner;
        m_used = 0;
        m_hold = (CPU_GAP > 1) ? CPU_GAP - 1 : 0;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (cpu_arbitrate && dma_req != '0) begin
      found = 0;
      for (int k = 1; k <= NCHAN; k++) begin
        c = (m_last + k) % NCHAN;
        if (!found && bit_of(dma_req, c)) begin
          found = 1;
          m_owner = c;
        end
      end
      m_dma = 1;
      m_used = 0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    dma_req = '0;
    cpu_arbitrate = 1'b0;
    sample();
    advance();
    reset = 1'b0;
  endtask

  typedef struct {
    bit               rst;
    logic [NCHAN-1:0] req;
    bit               arb;
    logic [NCHAN-1:0] ack;
    bit               cack;
    logic [2:0]       own;
    logic [ADDR_W-1:0] addr;
  } vec_t;

  localparam logic [ADDR_W-1:0] CA = 22'o0001000;
  localparam logic [ADDR_W-1:0] DA = 22'o0400123;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1, 4'hF, 0, 4'h0, 1, 3'd0, CA};
    tbl[1]  = '{0, 4'hF, 0, 4'h0, 1, 3'd0, CA};
    tbl[2]  = '{0, 4'hF, 0, 4'h0, 1, 3'd0, CA};
    tbl[3]  = '{0, 4'h4, 1, 4'h0, 1, 3'd0, CA};
    tbl[4]  = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};
    tbl[5]  = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};
    tbl[6]  = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};
    tbl[7]  = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};
    tbl[8]  = '{0, 4'h4, 1, 4'h0, 1, 3'd0, CA};
    tbl[9]  = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};
    tbl[10] = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};
    tbl[11] = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};
    tbl[12] = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};
    tbl[13] = '{0, 4'h4, 1, 4'h0, 1, 3'd0, CA};
    tbl[14] = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};
    tbl[15] = '{0, 4'h4, 1, 4'h4, 0, 3'd2, DA};

    reset = 1'b1;
    cpu_addr = CA; cpu_data = 16'h1234;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte_op = 1'b0;
    cpu_arbitrate = 1'b0;
    dma_req = '0; dma_rd = '0; dma_wr = '0;
    dma_addr = 72'({$urandom, $urandom, $urandom});
    dma_addr[2*DMA_ADDR_W +: DMA_ADDR_W] = 18'o400123;
    dma_data = {$urandom, $urandom};
    #1;
    model_step();
    @(posedge clk);
    #1;

    // Vector table: reset hold-off, then channel 2 streaming.
    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst;
      dma_req = tbl[i].req;
      cpu_arbitrate = tbl[i].arb;
      sample();
      chk($sformatf("tbl%0d_ack", i), 32'(dma_ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_cack", i), 32'(cpu_ack), 32'(tbl[i].cack));
      chk($sformatf("tbl%0d_own", i), 32'(owner), 32'(tbl[i].own));
      chk($sformatf("tbl%0d_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
      advance();
    end

    // All channels requesting: 0,1,2,3,0 with one CPU cycle between.
    do_reset();
    dma_req = 4'hF;
    cpu_arbitrate = 1'b1;
    for (int c = 0; c < 25; c++) begin
      sample();
      chk($sformatf("rr%0d", c), 32'(dma_ack),
          (c % 5 == 0) ? 32'd0 : 32'(1) << ((c / 5) % 4));
      advance();
    end

    // Channel 1 drops after two ack cycles; channel 2 is next.
    do_reset();
    dma_req = 4'b0110;
    cpu_arbitrate = 1'b1;
    sample(); chk("drop_c0", 32'(cpu_ack), 32'd1); advance();
    sample(); chk("drop_c1", 32'(dma_ack), 32'b0010); advance();
    dma_req = 4'b0100;
    sample();
    chk("drop_c2", 32'(dma_ack), 32'b0010);
    chk("drop_bc", 32'(burst_cnt), 32'd1);
    advance();
    sample();
    chk("drop_c3", 32'(dma_ack), 32'd0);
    chk("drop_c3_cack", 32'(cpu_ack), 32'd1);
    advance();
    sample(); chk("drop_c4", 32'(dma_ack), 32'b0100); advance();

    // Reset in the third beat of a channel 1 burst.
    do_reset();
    dma_req = 4'b0010;
    cpu_arbitrate = 1'b1;
    sample(); advance();
    sample(); chk("mid_c1", 32'(dma_ack), 32'b0010); advance();
    sample(); chk("mid_c2", 32'(dma_ack), 32'b0010); advance();
    reset = 1'b1;
    dma_req = 4'hF;
    sample(); chk("mid_c3", 32'(dma_ack), 32'b0010); advance();
    reset = 1'b0;
    sample();
    chk("mid_c4_cack", 32'(cpu_ack), 32'd1);
    chk("mid_c4_ack", 32'(dma_ack), 32'd0);
    advance();
    sample(); chk("mid_c5", 32'(dma_ack), 32'b0001); advance();

    // CPU write strobes during a burst must not reach RAM.
    do_reset();
    dma_req = 4'b0100;
    cpu_arbitrate = 1'b1;
    cpu_wr = 1'b1; cpu_byte_op = 1'b1; cpu_addr = CA;
    dma_wr = 4'b1011;
    sample();
    chk("cw_c0_wr", 32'(ram_wr), 32'd1);
    chk("cw_c0_bo", 32'(ram_byte_op), 32'd1);
    advance();
    sample();
    chk("cw_c1_wr", 32'(ram_wr), 32'd0);
    chk("cw_c1_bo", 32'(ram_byte_op), 32'd0);
    chk("cw_c1_addr", 32'(ram_addr), 32'(DA));
    advance();
    dma_wr = 4'b0100;
    sample(); chk("cw_c2_wr", 32'(ram_wr), 32'd1); advance();
    cpu_wr = 1'b0; cpu_byte_op = 1'b0; dma_wr = '0;

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) dma_req = 4'($urandom);
      cpu_arbitrate = ($urandom_range(0, 3) != 0);
      cpu_addr = 22'($urandom);
      cpu_data = 16'($urandom);
      cpu_rd = 1'($urandom);
      cpu_wr = 1'($urandom);
      cpu_byte_op = 1'($urandom);
      dma_rd = 4'($urandom);
      dma_wr = 4'($urandom);
      dma_data = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0)
        dma_addr = 72'({$urandom, $urandom, $urandom});
      sample();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
